// File: rtl/or_reduce_seq.sv
// or_reduce_seq: clocked, streaming successor to the 3-input OR gate.
// Each frame of one or more WIDTH-bit beats is reduced to one result bit
// with a selectable function (OR/AND/XOR and their inversions). One result
// is returned per frame on a valid/ready output stream.
module or_reduce_seq #(
   parameter int WIDTH     = 3,
   parameter int MAX_BEATS = 16,
   parameter int CW        = $clog2(MAX_BEATS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic             in_last,
   input  logic [2:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             s,
   output logic [CW-1:0]    beats,
   output logic             overflow,
   output logic             mode_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [1:0] OP_OR  = 2'd0;
   localparam logic [1:0] OP_AND = 2'd1;
   localparam logic [1:0] OP_XOR = 2'd2;

   state_t          state;
   state_t          state_nxt;
   logic            ready_en;
   logic [2:0]      mode_q;
   logic            acc;
   logic [CW-1:0]   cnt;

   logic [2:0]      eff_mode;
   logic [1:0]      op;
   logic            inv;
   logic            err;
   logic            red;
   logic            acc_nxt;
   logic [CW-1:0]   cnt_nxt;
   logic            at_max;
   logic            close;
   logic            close_ovf;
   logic            accept;
   logic            fire;

   // in_ready stays low through reset and rises on the first clock after it
   assign in_ready  = ready_en && (state != HOLD);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;
   assign fire      = out_valid && out_ready;

   // Decode the function for this beat: the live mode opens a frame, later beats use the latched one
   always_comb begin
      eff_mode = (state == IDLE) ? mode : mode_q;
      op       = OP_OR;
      inv      = 1'b0;
      err      = 1'b0;
      case (eff_mode)
         3'd0: op = OP_OR;
         3'd1: op = OP_AND;
         3'd2: op = OP_XOR;
         3'd3: begin op = OP_OR;  inv = 1'b1; end
         3'd4: begin op = OP_AND; inv = 1'b1; end
         3'd5: begin op = OP_XOR; inv = 1'b1; end
         default: begin op = OP_OR; err = 1'b1; end
      endcase
   end

   // Reduce the beat, fold it into the running accumulator and work out whether the frame closes
   always_comb begin
      case (op)
         OP_AND:  red = &a;
         OP_XOR:  red = ^a;
         default: red = |a;
      endcase
      acc_nxt = red;
      if (state != IDLE) begin
         case (op)
            OP_AND:  acc_nxt = acc & red;
            OP_XOR:  acc_nxt = acc ^ red;
            default: acc_nxt = acc | red;
         endcase
      end
      cnt_nxt   = (state == IDLE) ? CW'(1) : cnt + CW'(1);
      at_max    = (cnt_nxt == CW'(MAX_BEATS));
      close     = in_last || at_max;
      close_ovf = at_max && !in_last;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: open/extend a frame on accept, release the result on output fire
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, ACC: begin
            if (accept) begin
               state_nxt = close ? HOLD : ACC;
            end
         end
         HOLD: begin
            if (fire) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Input-side enable that keeps in_ready low until the first clock out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   // Accumulator, beat counter and result registers; s and beats persist after the result is taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= 1'b0;
         cnt      <= '0;
         mode_q   <= 3'd0;
         s        <= 1'b0;
         beats    <= '0;
         overflow <= 1'b0;
         mode_err <= 1'b0;
      end else begin
         if (accept) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (state == IDLE) begin
               mode_q <= mode;
            end
            if (close) begin
               s        <= acc_nxt ^ inv;
               beats    <= cnt_nxt;
               overflow <= close_ovf;
               mode_err <= err;
            end
         end
         if (fire) begin
            overflow <= 1'b0;
            mode_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_or_reduce_seq.sv
// tb_or_reduce_seq: scoreboard bench for or_reduce_seq (WIDTH=3, MAX_BEATS=4).
// Beats are driven through a small frame model that pushes the expected
// result when a frame closes; a monitor pops and compares on each output fire.
module tb_or_reduce_seq;

   localparam int WIDTH = 3;
   localparam int MAXB  = 4;
   localparam int CW    = $clog2(MAXB + 1);

   typedef struct packed {
      logic          s;
      logic [CW-1:0] beats;
      logic          ovf;
      logic          err;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic             in_last;
   logic [2:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic             s;
   logic [CW-1:0]    beats;
   logic             overflow;
   logic             mode_err;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb[$];
   int   fire_cyc[$];

   // Frame model state
   logic          m_active = 1'b0;
   logic [2:0]    m_mode   = 3'd0;
   logic          m_acc    = 1'b0;
   int            m_cnt    = 0;

   or_reduce_seq #(.WIDTH(WIDTH), .MAX_BEATS(MAXB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .in_last  (in_last),
      .mode     (mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .s        (s),
      .beats    (beats),
      .overflow (overflow),
      .mode_err (mode_err)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to measure result spacing
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic reduceBeat(input logic [2:0] md, input logic [WIDTH-1:0] v);
      case (md)
         3'd1, 3'd4: return &v;
         3'd2, 3'd5: return ^v;
         default:    return |v;
      endcase
   endfunction

   function automatic logic combine(input logic [2:0] md, input logic x, input logic y);
      case (md)
         3'd1, 3'd4: return x & y;
         3'd2, 3'd5: return x ^ y;
         default:    return x | y;
      endcase
   endfunction

   // Drive one beat, wait (bounded) for it to be accepted, then update the frame model
   task automatic applyStimulus(input logic [WIDTH-1:0] a_v, input logic last_v, input logic [2:0] mode_v);
      int   waited = 0;
      exp_t e;
      logic r;
      a        = a_v;
      in_last  = last_v;
      mode     = mode_v;
      in_valid = 1'b1;
      while (!in_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         checkOutput("in_ready_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!m_active) begin
         m_mode   = mode_v;
         m_acc    = reduceBeat(mode_v, a_v);
         m_cnt    = 1;
         m_active = 1'b1;
      end else begin
         r     = reduceBeat(m_mode, a_v);
         m_acc = combine(m_mode, m_acc, r);
         m_cnt++;
      end
      if (last_v || m_cnt == MAXB) begin
         e.s      = m_acc ^ (m_mode >= 3'd3 && m_mode <= 3'd5);
         e.beats  = CW'(m_cnt);
         e.ovf    = !last_v;
         e.err    = (m_mode >= 3'd6);
         sb.push_back(e);
         m_active = 1'b0;
      end
   endtask

   task automatic waitDrain();
      int n = 0;
      while (sb.size() > 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput("drain", sb.size(), 32'd0);
   endtask

   // Monitor: compare each result the DUT hands over against the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         fire_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            checkOutput("unexpected_result", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("s",        32'(s),        32'(e.s));
            checkOutput("beats",    32'(beats),    32'(e.beats));
            checkOutput("overflow", 32'(overflow), 32'(e.ovf));
            checkOutput("mode_err", 32'(mode_err), 32'(e.err));
         end
      end
   end

   // Global watchdog
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      in_last   = 1'b0;
      mode      = 3'd0;
      out_ready = 1'b1;

      // Reset state
      #12;
      checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_s",         32'(s),         32'd0);
      checkOutput("rst_beats",     32'(beats),     32'd0);
      checkOutput("rst_overflow",  32'(overflow),  32'd0);
      checkOutput("rst_mode_err",  32'(mode_err),  32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("rel_in_ready_pre", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      checkOutput("rel_in_ready_post", 32'(in_ready), 32'd1);

      // OR truth table, single-beat frames, one result every 2 cycles
      fire_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(WIDTH'(i), 1'b1, 3'd0);
      end
      waitDrain();
      checkOutput("tt_results", fire_cyc.size(), 32'd8);
      if (fire_cyc.size() == 8) begin
         checkOutput("tt_spacing", 32'(fire_cyc[7] - fire_cyc[0]), 32'd14);
      end

      // Multi-beat XOR (s=0) and XNOR (s=1)
      applyStimulus(3'b011, 1'b0, 3'd2);
      applyStimulus(3'b001, 1'b0, 3'd2);
      applyStimulus(3'b111, 1'b1, 3'd2);
      applyStimulus(3'b011, 1'b0, 3'd5);
      applyStimulus(3'b001, 1'b0, 3'd5);
      applyStimulus(3'b111, 1'b1, 3'd5);
      // NAND across beats (s=1), AND all-ones (s=1, beats=3)
      applyStimulus(3'b111, 1'b0, 3'd4);
      applyStimulus(3'b111, 1'b0, 3'd4);
      applyStimulus(3'b110, 1'b1, 3'd4);
      applyStimulus(3'b111, 1'b0, 3'd1);
      applyStimulus(3'b111, 1'b0, 3'd1);
      applyStimulus(3'b111, 1'b1, 3'd1);
      waitDrain();

      // Backpressure: result must hold steady while out_ready is low
      out_ready = 1'b0;
      applyStimulus(3'b001, 1'b1, 3'd0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_in_ready",  32'(in_ready),  32'd0);
         checkOutput("bp_s",         32'(s),         32'd1);
         checkOutput("bp_beats",     32'(beats),     32'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      waitDrain();
      checkOutput("post_fire_s_kept",     32'(s),     32'd1);
      checkOutput("post_fire_beats_kept", 32'(beats), 32'd1);

      // Overflow: 6 beats, in_last only on the 6th -> frames of 4 (ovf) and 2
      applyStimulus(3'b000, 1'b0, 3'd0);
      applyStimulus(3'b000, 1'b0, 3'd0);
      applyStimulus(3'b000, 1'b0, 3'd0);
      applyStimulus(3'b001, 1'b0, 3'd0);
      applyStimulus(3'b000, 1'b0, 3'd0);
      applyStimulus(3'b000, 1'b1, 3'd0);
      waitDrain();
      // in_last on the MAX_BEATS-th beat closes without overflow
      for (int i = 0; i < 3; i++) applyStimulus(3'b000, 1'b0, 3'd3);
      applyStimulus(3'b000, 1'b1, 3'd3);
      waitDrain();

      // Reset mid-frame after 2 beats drops the partial frame
      applyStimulus(3'b001, 1'b0, 3'd0);
      applyStimulus(3'b001, 1'b0, 3'd0);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_in_ready",  32'(in_ready),  32'd0);
      m_active = 1'b0;
      #10;
      rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(3'b100, 1'b1, 3'd0);
      waitDrain();

      // Reset while a result is pending drops it
      out_ready = 1'b0;
      applyStimulus(3'b111, 1'b1, 3'd0);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("holdrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("holdrst_beats",     32'(beats),     32'd0);
      sb.delete();
      m_active = 1'b0;
      out_ready = 1'b1;
      #10;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reserved mode: OR, no invert, mode_err set
      applyStimulus(3'b010, 1'b1, 3'd6);
      waitDrain();
      checkOutput("mode_err_cleared", 32'(mode_err), 32'd0);

      // Mode changes mid-frame are ignored: AND of 111,011,111 -> 0
      applyStimulus(3'b111, 1'b0, 3'd1);
      applyStimulus(3'b011, 1'b0, 3'd0);
      applyStimulus(3'b111, 1'b1, 3'd2);
      waitDrain();

      repeat (3) @(posedge clk);
      #1;
      checkOutput("final_out_valid", 32'(out_valid), 32'd0);
      checkOutput("final_queue",     sb.size(),      32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
